vgapll_ctrl: RTL
================

Name: vgapll_ctrl

Overview:
Reset sequencer and lock supervisor for the VGA pixel-clock PLL. It runs on the PLL's 50 MHz reference clock, drives the PLL reset, and qualifies the PLL's asynchronous locked flag. It asserts clk_valid only after lock has been continuously stable. On lock loss or timeout it re-sequences the PLL, and after too many failed attempts it parks in a fault state. Downstream VGA logic uses clk_valid to release its own reset in the outclk domain.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 1024, cycles to wait for locked after pll_rst release before retrying (>=1)
STABLE_CYCLES, 64, consecutive synchronized-locked cycles required before clk_valid (>=1)
MAX_RETRIES, 3, lock-timeout retries allowed before FAULT (0..7)
CNT_W, 16, width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1

Ports:
refclk  in  1  50 MHz reference clock; sole clock of this block
rst  in  1  asynchronous, active-high reset
locked  in  1  PLL lock flag; asynchronous to refclk
relock_req  in  1  single-cycle request to restart the sequence from RESET_PLL
pll_rst  out  1  reset to the PLL rst pin
clk_valid  out  1  high only in RUN; PLL output is usable
lock_lost  out  1  one-cycle pulse when lock drops while in RUN
fault  out  1  high in FAULT
retry_cnt  out  3  timeout retries consumed in the current sequence
state  out  3  current state encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4

Behaviour:
- locked passes through a 2-flop synchronizer (locked_s), giving 2 refclk cycles of latency. Only locked_s is used internally.
- All outputs are registered, with no combinational paths from inputs.
- Async reset (rst high) values:
  - state = RESET_PLL, cnt = 0, retry_cnt = 0
  - pll_rst = 1, clk_valid = 0, lock_lost = 0, fault = 0
  - synchronizer flops = 0
- RESET_PLL:
  - pll_rst = 1; cnt increments each cycle.
  - At cnt == RST_CYCLES-1: go to WAIT_LOCK and clear cnt. pll_rst is therefore high for exactly RST_CYCLES cycles after rst deasserts.
- WAIT_LOCK:
  - pll_rst = 0.
  - If locked_s: go to STABLE, cnt = 0.
  - Else if cnt == LOCK_TIMEOUT-1:
    - If retry_cnt == MAX_RETRIES: go to FAULT.
    - Otherwise retry_cnt += 1 and go to RESET_PLL, cnt = 0.
  - Else cnt += 1.
  - If locked_s rises on the timeout cycle, lock wins.
- STABLE:
  - pll_rst = 0.
  - If !locked_s: go to WAIT_LOCK with cnt = 0 and retry_cnt unchanged (glitch tolerance; this does not consume a retry).
  - Else if cnt == STABLE_CYCLES-1: go to RUN and clear retry_cnt to 0.
  - Else cnt += 1.
- RUN:
  - clk_valid = 1.
  - If !locked_s: lock_lost pulses for exactly 1 cycle, clk_valid drops on the same edge, go to RESET_PLL, cnt = 0.
- FAULT:
  - pll_rst = 1, fault = 1, clk_valid = 0.
  - Stays until relock_req or rst.
- relock_req:
  - Highest priority, in every state: next state RESET_PLL, cnt = 0, retry_cnt = 0, fault cleared.
  - If it coincides with lock loss in RUN, lock_lost still pulses.
  - relock_req held high keeps the block in RESET_PLL with cnt stuck at 0.
- Mid-operation rst: immediate asynchronous return to reset values regardless of state. clk_valid falls without waiting for an edge.
- cnt never wraps. It is cleared on every state transition and saturates at most at its terminal value.
- Output decode by state:
  - pll_rst = state in {RESET_PLL, FAULT}
  - clk_valid = (state == RUN)
  - fault = (state == FAULT)

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal bring-up: release rst, raise locked 5 cycles later -> pll_rst high exactly 4 cycles; clk_valid rises 2 (sync) + 8 cycles after locked rises; retry_cnt = 0; fault = 0.
2. Glitch in STABLE: locked drops for 3 cycles after 5 stable cycles -> state returns to WAIT_LOCK, retry_cnt stays 0, clk_valid stays 0; after locked returns, a full 8-cycle stable count restarts before RUN.
3. Timeouts to fault: locked held 0 -> three WAIT_LOCK windows of 20 cycles; retry_cnt steps 0->1->2; on the third timeout state = 4 and fault = 1 with pll_rst = 1; the block stays there for 200 cycles.
4. Lock loss in RUN: drop locked while clk_valid = 1 -> lock_lost high for 1 cycle, 2 cycles after the drop; clk_valid falls on the same edge; pll_rst high for 4 cycles, then the sequence resumes.
5. relock_req in FAULT and coincident with a timeout: pulse relock_req -> fault = 0, retry_cnt = 0, state = 0 next cycle; relock_req wins over a coincident timeout transition.
6. Async rst mid-RUN: assert rst between clock edges -> clk_valid = 0 and pll_rst = 1 immediately, without waiting for a refclk edge.

Source files
------------

// File: rtl/vgapll_ctrl.sv
// Reset sequencer and lock supervisor for the VGA pixel-clock PLL.
// Holds the PLL in reset, waits for a stable synchronized lock, then flags clk_valid.
module vgapll_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       clk_valid,
  output logic       lock_lost,
  output logic       fault,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  // state     | meaning
  // RESET_PLL | pll_rst held high for RST_CYCLES
  // WAIT_LOCK | pll_rst released, waiting up to LOCK_TIMEOUT for locked_s
  // STABLE    | locked_s seen, counting STABLE_CYCLES consecutive lock cycles
  // RUN       | clk_valid high; any lock drop re-sequences
  // FAULT     | retries exhausted; PLL parked in reset until relock_req
  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             lost_d;
  logic             sync1_q, locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= locked;
      locked_s <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // lock wins over a coincident timeout
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q == 3'(MAX_RETRIES)) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_RESET_PLL;
            retry_d = retry_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end
      end
      S_FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    // relock_req overrides everything except the lock_lost report
    if (relock_req) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst   <= 1'b1;
      clk_valid <= 1'b0;
      lock_lost <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst   <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      clk_valid <= (state_d == S_RUN);
      lock_lost <= lost_d;
      fault     <= (state_d == S_FAULT);
    end
  end

  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
